// File: rtl/traffic_pkg.sv
// Shared state type, default timing constants and a counter-width helper
// for the pedestrian-crossing request logic.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    LOCKOUT = 2'd3
  } ped_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_LOCKOUT_CYCLES  = 200_000_000;
  localparam int SYNC_STAGES             = 2;

  // Counter width for a terminal count of n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ped_request_ctrl_if.sv
// Button, light-controller and indicator signals of the pedestrian request block.
interface ped_request_ctrl_if;

  logic btn_raw;
  logic ped_green;
  logic request;
  logic btn_level;
  logic lockout;

  modport master (
    output btn_raw,
    output ped_green,
    input  request,
    input  btn_level,
    input  lockout
  );

  modport slave (
    input  btn_raw,
    input  ped_green,
    output request,
    output btn_level,
    output lockout
  );

endinterface

// File: rtl/debouncer.sv
// Two-flop synchronizer plus stability counter: the level output follows the
// synchronized input only after it has differed for DEBOUNCE_CYCLES cycles.
module debouncer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign synced = sync_q[SYNC_STAGES-1];

  // The counter holds how many earlier cycles already differed, so the
  // level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: debounces the push-button and sequences the
// IDLE/PENDING/SERVING/LOCKOUT handshake with the light controller.
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES
) (
  input logic               clk,
  input logic               reset_n,
  ped_request_ctrl_if.slave bus
);

  localparam int                LOCK_W    = cnt_width(LOCKOUT_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

  logic                 btn_level;
  logic                 btn_prev_q, btn_prev_d;
  logic                 press_q, press_d;
  logic [SYNC_STAGES:0] green_q, green_d;
  logic                 green_rise, green_fall;
  ped_state_t           state_q, state_d;
  logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                 request_q, request_d;
  logic                 lockout_q, lockout_d;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (bus.btn_raw),
    .level  (btn_level)
  );

  // Top bit of green_q is the previous synchronized value, used for edges.
  assign green_d    = {green_q[SYNC_STAGES-1:0], bus.ped_green};
  assign green_rise =  green_q[SYNC_STAGES-1] & ~green_q[SYNC_STAGES];
  assign green_fall = ~green_q[SYNC_STAGES-1] &  green_q[SYNC_STAGES];

  assign btn_prev_d = btn_level;
  assign press_d    = btn_level & ~btn_prev_q;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (press_q) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (green_rise) begin
          state_d = SERVING;
        end
      end
      SERVING: begin
        if (green_fall) begin
          state_d    = LOCKOUT;
          lock_cnt_d = LOCK_LOAD;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register.
  always_comb begin
    request_d = (state_d == PENDING);
    lockout_d = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
      green_q    <= '0;
      lock_cnt_q <= '0;
      request_q  <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      btn_prev_q <= btn_prev_d;
      press_q    <= press_d;
      green_q    <= green_d;
      lock_cnt_q <= lock_cnt_d;
      request_q  <= request_d;
      lockout_q  <= lockout_d;
    end
  end

  assign bus.request   = request_q;
  assign bus.btn_level = btn_level;
  assign bus.lockout   = lockout_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: phase table, hand-written corner sequences and
// random stimulus, all compared against a cycle-stamped reference model.
module tb_ped_request_ctrl;

  localparam int DEB  = 4;
  localparam int LOCK = 8;
  localparam int NMAX = 20000;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_WALK = 2;
  localparam int M_LOCK = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ped_request_ctrl_if bus ();

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: input history stamped by edge number since reset.
  bit raw_a [NMAX];
  bit grn_a [NMAX];
  bit lvl_a [NMAX];
  int cyc = 0;
  int base = 0;
  bit m_level;
  int m_run;
  int m_mode;
  int lock_end;

  function automatic bit past_raw(input int k);
    return (k < base || k >= NMAX) ? 1'b0 : raw_a[k];
  endfunction

  function automatic bit past_grn(input int k);
    return (k < base || k >= NMAX) ? 1'b0 : grn_a[k];
  endfunction

  function automatic bit past_lvl(input int k);
    return (k < base || k >= NMAX) ? 1'b0 : lvl_a[k];
  endfunction

  task automatic model_reset();
    base    = cyc;
    m_level = 1'b0;
    m_run   = 0;
    m_mode  = M_IDLE;
  endtask

  // One rising edge: synced input is the raw value two edges back; a press
  // acts two edges after the debounced level rose; green edges act two
  // edges after they were sampled.
  task automatic model_step();
    bit s2, press, rise, fall;
    if (cyc < NMAX) begin
      raw_a[cyc] = bus.btn_raw;
      grn_a[cyc] = bus.ped_green;
    end
    s2 = past_raw(cyc - 2);
    if (s2 != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = s2;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    if (cyc < NMAX) lvl_a[cyc] = m_level;
    press = past_lvl(cyc - 2) && !past_lvl(cyc - 3);
    rise  = past_grn(cyc - 2) && !past_grn(cyc - 3);
    fall  = !past_grn(cyc - 2) && past_grn(cyc - 3);
    if (m_mode == M_LOCK) begin
      if (cyc >= lock_end) m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (press) m_mode = M_WAIT;
    end else if (m_mode == M_WAIT) begin
      if (rise) m_mode = M_WALK;
    end else if (fall) begin
      m_mode   = M_LOCK;
      lock_end = cyc + LOCK;
    end
    cyc++;
  endtask

  task automatic tick();
    bit er, el;
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    er = (m_mode == M_WAIT);
    el = (m_mode == M_LOCK);
    n_vec++;
    if (bus.request !== er || bus.lockout !== el || bus.btn_level !== m_level) begin
      n_err++;
      $display("FAIL model edge=%0d req/lock/lvl got %b%b%b expected %b%b%b",
               cyc, bus.request, bus.lockout, bus.btn_level, er, el, m_level);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect3(input string name, input bit r, input bit l, input bit v);
    n_vec++;
    if (bus.request !== r || bus.lockout !== l || bus.btn_level !== v) begin
      n_err++;
      $display("FAIL %s req/lock/lvl got %b%b%b expected %b%b%b",
               name, bus.request, bus.lockout, bus.btn_level, r, l, v);
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic pulse_reset(input string name);
    #2;
    reset_n = 1'b0;
    #1;
    expect3(name, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit btn;
    bit grn;
    int cycles;
    bit req;
    bit lock;
    bit lvl;
  } vec_t;

  vec_t tbl [15];

  initial begin
    bus.btn_raw   = 1'b0;
    bus.ped_green = 1'b0;
    reset_n       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    expect3("reset_state", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Phases: {btn, green, cycles held, request, lockout, btn_level after}.
    tbl[0]  = '{1'b1, 1'b0,  3, 1'b0, 1'b0, 1'b0};  // 3-cycle glitch
    tbl[1]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};  // glitch never lands
    tbl[2]  = '{1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b0};  // still debouncing
    tbl[3]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1};  // level 6 edges after drive
    tbl[4]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b1};  // request 2 edges later
    tbl[6]  = '{1'b1, 1'b0,  3, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0};  // held after release
    tbl[8]  = '{1'b0, 1'b1,  2, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0};  // drop 3 edges after rise
    tbl[10] = '{1'b0, 1'b1, 17, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0};  // lockout 3 edges after fall
    tbl[13] = '{1'b0, 1'b0,  7, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0};  // exactly 8 cycles

    for (int i = 0; i < 15; i++) begin
      bus.btn_raw   = tbl[i].btn;
      bus.ped_green = tbl[i].grn;
      ticks(tbl[i].cycles);
      expect3($sformatf("table_%0d", i), tbl[i].req, tbl[i].lock, tbl[i].lvl);
    end

    // Presses during SERVING and LOCKOUT are dropped, not queued.
    bus.btn_raw = 1'b1; ticks(8);
    bus.btn_raw = 1'b0; ticks(8);
    expect3("a_pending", 1'b1, 1'b0, 1'b0);
    bus.ped_green = 1'b1; ticks(3);
    expect3("a_serving", 1'b0, 1'b0, 1'b0);
    bus.btn_raw = 1'b1; ticks(8);
    bus.btn_raw = 1'b0; ticks(8);
    expect3("a_press_in_serving", 1'b0, 1'b0, 1'b0);
    bus.ped_green = 1'b0; bus.btn_raw = 1'b1; ticks(3);
    expect3("a_lock_rise", 1'b0, 1'b1, 1'b0);
    ticks(5);
    expect3("a_press_in_lockout", 1'b0, 1'b1, 1'b1);
    ticks(3);
    expect3("a_not_queued", 1'b0, 1'b0, 1'b1);
    bus.btn_raw = 1'b0; ticks(8);

    // Press whose pulse lands one edge after lockout ends is accepted.
    bus.btn_raw = 1'b1; ticks(8);
    bus.btn_raw = 1'b0; ticks(8);
    bus.ped_green = 1'b1; ticks(3);
    bus.ped_green = 1'b0; ticks(4);
    expect3("b_lockout", 1'b0, 1'b1, 1'b0);
    bus.btn_raw = 1'b1; ticks(6);
    expect3("b_level_in_lockout", 1'b0, 1'b1, 1'b1);
    ticks(1);
    expect3("b_lockout_end", 1'b0, 1'b0, 1'b1);
    ticks(1);
    expect3("b_press_after_lockout", 1'b1, 1'b0, 1'b1);

    // Green already high when the press is accepted: wait for a fresh rise.
    bus.ped_green = 1'b1; ticks(3);
    bus.btn_raw = 1'b0; bus.ped_green = 1'b0; ticks(12);
    expect3("c_idle", 1'b0, 1'b0, 1'b0);
    bus.ped_green = 1'b1; ticks(5);
    bus.btn_raw = 1'b1; ticks(8);
    expect3("c_pending_green_high", 1'b1, 1'b0, 1'b1);
    ticks(20);
    expect3("c_level_not_service", 1'b1, 1'b0, 1'b1);
    bus.btn_raw = 1'b0; bus.ped_green = 1'b0; ticks(5);
    bus.ped_green = 1'b1; ticks(2);
    expect3("c_before_rise", 1'b1, 1'b0, 1'b0);
    ticks(1);
    expect3("c_served_on_rise", 1'b0, 1'b0, 1'b0);
    bus.ped_green = 1'b0; ticks(12);

    // Press and green rise act on the same edge in IDLE.
    bus.btn_raw = 1'b1; ticks(5);
    bus.ped_green = 1'b1; ticks(2);
    expect3("d_before", 1'b0, 1'b0, 1'b1);
    ticks(1);
    expect3("d_press_and_rise", 1'b1, 1'b0, 1'b1);
    ticks(5);
    expect3("d_still_pending", 1'b1, 1'b0, 1'b1);
    bus.ped_green = 1'b0; ticks(3);
    bus.ped_green = 1'b1; ticks(3);
    bus.ped_green = 1'b0; bus.btn_raw = 1'b0; ticks(12);

    // Reset mid-PENDING with the button held through release.
    bus.btn_raw = 1'b1; ticks(8);
    expect3("e_pending", 1'b1, 1'b0, 1'b1);
    pulse_reset("e_reset_pending");
    ticks(6);
    expect3("e_rearm_level", 1'b0, 1'b0, 1'b1);
    ticks(1);
    expect3("e_rearm_wait", 1'b0, 1'b0, 1'b1);
    ticks(1);
    expect3("e_rearm_request", 1'b1, 1'b0, 1'b1);

    // Reset mid-LOCKOUT discards the remaining lockout.
    bus.btn_raw = 1'b0; bus.ped_green = 1'b1; ticks(3);
    bus.ped_green = 1'b0; ticks(5);
    expect3("e_lockout", 1'b0, 1'b1, 1'b0);
    pulse_reset("e_reset_lockout");
    ticks(3);
    expect3("e_after_reset", 1'b0, 1'b0, 1'b0);
    bus.btn_raw = 1'b1; ticks(8);
    expect3("e_lockout_discarded", 1'b1, 1'b0, 1'b1);

    // Random bouncing button and slow green toggles against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.btn_raw = ~bus.btn_raw;
      if ($urandom_range(0, 24) == 0) bus.ped_green = ~bus.ped_green;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
